fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 106 ++++++++++
 tb/tb_fifo_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops one word per frame from a registered-read FIFO and sends it as 8N1-style serial: start, DATA_W bits LSB first, stop.
// Pop to first start-bit cycle is 2 clks; no pop while busy, and tx_en only gates the start of the next frame.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                baud_end;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (tx_en && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        // Registered FIFO read data is valid only in this cycle.
        baud_d  = '0;
        shift_d = fifo_data;
        state_d = START;
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d     = '0;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level depends only on flops, so it cannot glitch on FIFO inputs.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign fifo_rd = rstn & (state_q == IDLE) & tx_en & ~fifo_empty;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: default instance for framing/flow/reset cases, CLKS_PER_BIT=2 instance for a streamed burst.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tx_en, fifo_empty, fifo_rd, tx, busy, frame_done;
  logic [7:0] fifo_data;
  logic       tx_en2, fifo_empty2, fifo_rd2, tx2, busy2, frame_done2;
  logic [7:0] fifo_data2;

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en2), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_rd(fifo_rd2), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
  );

  int         n_err, n_chk, cyc_n;
  logic [7:0] q[$], q2[$], src[$], exp_q[$];
  bit         tx_log[$], busy_log[$], tx2_log[$];
  int         rd_cyc[$], fd_cyc[$], rd2_cyc[$], fd2_cyc[$];
  logic       rd_pend, rd2_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: FIFO flags from the model, sample at negedge, pop registered data just after posedge.
  task automatic cyc();
    fifo_empty  = (q.size() == 0);
    fifo_empty2 = (q2.size() == 0);
    @(negedge clk);
    tx_log.push_back(tx);
    busy_log.push_back(busy);
    tx2_log.push_back(tx2);
    if (fifo_rd)     rd_cyc.push_back(cyc_n);
    if (frame_done)  fd_cyc.push_back(cyc_n);
    if (fifo_rd2)    rd2_cyc.push_back(cyc_n);
    if (frame_done2) fd2_cyc.push_back(cyc_n);
    rd_pend  = fifo_rd;
    rd2_pend = fifo_rd2;
    @(posedge clk);
    #1;
    if (rd_pend && q.size() > 0)   fifo_data  = q.pop_front();
    if (rd2_pend && q2.size() > 0) fifo_data2 = q2.pop_front();
    cyc_n++;
  endtask

  function automatic int n_low(input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (i < tx_log.size() && !tx_log[i]) n++;
    return n;
  endfunction

  function automatic int n_busy(input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (i < busy_log.size() && busy_log[i]) n++;
    return n;
  endfunction

  // Samples mid-bit of each data bit of a frame whose pop was at cycle c.
  function automatic logic [7:0] decode(input int c, input int cpb, input bit second);
    logic [7:0] b = '0;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = c + 2 + cpb * (1 + k) + cpb / 2;
      if (second) b[k] = (idx < tx2_log.size()) ? tx2_log[idx] : 1'b0;
      else        b[k] = (idx < tx_log.size())  ? tx_log[idx]  : 1'b0;
    end
    return b;
  endfunction

  task automatic clear_logs();
    rd_cyc.delete();
    fd_cyc.delete();
  endtask

  initial begin
    int s, c, r0, r1, n, g;
    logic [39:0] obs;
    logic [7:0]  w;
    n_err = 0; n_chk = 0; cyc_n = 0;
    rstn = 1'b0; tx_en = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
    tx_en2 = 1'b0; fifo_empty2 = 1'b1; fifo_data2 = '0;

    // Reset held with a non-empty FIFO and tx_en high: no pop, line idle.
    q.push_back(8'hA5);
    @(posedge clk);
    #1;
    repeat (3) cyc();
    check("rst_rd", rd_cyc.size(), 0);
    check("rst_tx_low", n_low(0, 3), 0);
    check("rst_busy", n_busy(0, 3), 0);
    check("rst_fd", fd_cyc.size(), 0);
    q.delete();
    rstn = 1'b1;

    repeat (100) cyc();
    check("idle_rd", rd_cyc.size(), 0);
    check("idle_tx_low", n_low(3, 103), 0);
    check("idle_busy", n_busy(3, 103), 0);

    // Single 0xA5 frame at default timing.
    clear_logs();
    s = cyc_n;
    q.push_back(8'hA5);
    repeat (60) cyc();
    check("a5_rd_n", rd_cyc.size(), 1);
    c = (rd_cyc.size() > 0) ? rd_cyc[0] : s;
    check("a5_rd_at", c, s);
    for (int i = 0; i < 40; i++) obs[39-i] = tx_log[c+2+i];
    check("a5_wave", obs, 40'h0F0F00F0FF);
    check("a5_pre_tx", {tx_log[c], tx_log[c+1]}, 2'b11);
    check("a5_fd_n", fd_cyc.size(), 1);
    check("a5_fd_lat", (fd_cyc.size() > 0) ? fd_cyc[0] - c : -1, 41);
    check("a5_busy", n_busy(c, c + 43), 41);

    // Back-to-back 0x00 then 0xFF.
    clear_logs();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    repeat (100) cyc();
    check("b2b_rd_n", rd_cyc.size(), 2);
    r0 = (rd_cyc.size() > 0) ? rd_cyc[0] : 0;
    r1 = (rd_cyc.size() > 1) ? rd_cyc[1] : 0;
    check("b2b_spacing", r1 - r0, 42);
    g = 0;
    for (int i = r0 + 38; i < tx_log.size() && tx_log[i]; i++) g++;
    check("b2b_gap", g, 6);
    check("b2b_w0", decode(r0, 4, 1'b0), 8'h00);
    check("b2b_w1", decode(r1, 4, 1'b0), 8'hFF);

    // tx_en gating: hold off, release, then drop mid-DATA.
    clear_logs();
    tx_en = 1'b0;
    q.push_back(8'h5A);
    repeat (10) cyc();
    check("en_hold_rd", rd_cyc.size(), 0);
    s = cyc_n;
    tx_en = 1'b1;
    cyc();
    check("en_rd_at", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, s);
    repeat (10) cyc();
    tx_en = 1'b0;
    q.push_back(8'h77);
    repeat (50) cyc();
    check("en_rd_n", rd_cyc.size(), 1);
    check("en_fd_n", fd_cyc.size(), 1);
    check("en_word", decode(s, 4, 1'b0), 8'h5A);
    q.delete();

    // One-cycle reset during DATA bit 3 of 0x3C, then 0x81 follows.
    clear_logs();
    s = cyc_n;
    tx_en = 1'b1;
    q.push_back(8'h3C);
    q.push_back(8'h81);
    repeat (19) cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    repeat (60) cyc();
    check("mrst_tx", tx_log[s+20], 1'b1);
    check("mrst_busy", busy_log[s+20], 1'b0);
    check("mrst_rd_n", rd_cyc.size(), 2);
    check("mrst_rd_at", (rd_cyc.size() > 1) ? rd_cyc[1] : -1, s + 20);
    check("mrst_fd_n", fd_cyc.size(), 1);
    check("mrst_word", decode((rd_cyc.size() > 1) ? rd_cyc[1] : 0, 4, 1'b0), 8'h81);
    check("mrst_q_left", q.size(), 0);
    tx_en = 1'b0;

    // Streamed burst at CLKS_PER_BIT=2 through an 8-deep FIFO model.
    for (int k = 0; k < 16; k++) begin
      w = 8'($urandom_range(0, 255));
      src.push_back(w);
      exp_q.push_back(w);
    end
    tx_en2 = 1'b1;
    n = 0;
    while (fd2_cyc.size() < 16 && n < 800) begin
      if (q2.size() < 8 && src.size() > 0) q2.push_back(src.pop_front());
      cyc();
      n++;
    end
    check("burst_done", fd2_cyc.size(), 16);
    check("burst_rd_n", rd2_cyc.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("burst_w%0d", k),
            decode((k < rd2_cyc.size()) ? rd2_cyc[k] : 0, 2, 1'b1), exp_q[k]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
